// File: rtl/multicycle_control_unit_pkg.sv
// Shared encodings for the multicycle MIPS controller: FSM states, ALU/mux select codes,
// default opcodes and the packed control-word struct driven by the state decoder.
package multicycle_control_unit_pkg;

  typedef enum logic [3:0] {
    ST_FETCH     = 4'd0,
    ST_DECODE    = 4'd1,
    ST_MEM_ADDR  = 4'd2,
    ST_MEM_RD    = 4'd3,
    ST_MEM_WB    = 4'd4,
    ST_MEM_WR    = 4'd5,
    ST_R_EXEC    = 4'd6,
    ST_R_WB      = 4'd7,
    ST_BRANCH    = 4'd8,
    ST_JUMP      = 4'd9,
    ST_ADDI_EXEC = 4'd10,
    ST_ADDI_WB   = 4'd11,
    ST_TRAP      = 4'd12
  } stateT;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam int DEF_OP_RTYPE = 0;
  localparam int DEF_OP_LW    = 35;
  localparam int DEF_OP_SW    = 43;
  localparam int DEF_OP_BEQ   = 4;
  localparam int DEF_OP_J     = 2;
  localparam int DEF_OP_ADDI  = 8;

  typedef struct packed {
    logic       pcWrite;
    logic       pcWriteCond;
    logic       iorD;
    logic       memRead;
    logic       memWrite;
    logic       irWrite;
    logic       memtoReg;
    logic       regDst;
    logic       regWrite;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] aluOp;
    logic [1:0] pcSource;
    logic       instrDone;
    logic       illegal;
  } ctrlT;

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// Combinational state -> control-word decoder, zero latency; memReady only gates the
// FETCH IR/PC loads and the MEM_WR completion pulse, wait states are held by the FSM.
module multicycle_ctrl_decode
  import multicycle_control_unit_pkg::*;
(
  input  logic [3:0] state,
  input  logic       memReady,
  output ctrlT       ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      ST_FETCH: begin
        ctrl.memRead  = 1'b1;
        ctrl.aluSrcB  = SRCB_FOUR;
        ctrl.aluOp    = ALUOP_ADD;
        ctrl.pcSource = PCSRC_ALU;
        // IR and PC only load once the instruction word is actually back
        ctrl.irWrite  = memReady;
        ctrl.pcWrite  = memReady;
      end
      ST_DECODE: begin
        ctrl.aluSrcB = SRCB_IMM_SH;
        ctrl.aluOp   = ALUOP_ADD;
      end
      ST_MEM_ADDR, ST_ADDI_EXEC: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluSrcB = SRCB_IMM;
        ctrl.aluOp   = ALUOP_ADD;
      end
      ST_MEM_RD: begin
        ctrl.memRead = 1'b1;
        ctrl.iorD    = 1'b1;
      end
      ST_MEM_WB: begin
        ctrl.regWrite  = 1'b1;
        ctrl.memtoReg  = 1'b1;
        ctrl.instrDone = 1'b1;
      end
      ST_MEM_WR: begin
        ctrl.memWrite  = 1'b1;
        ctrl.iorD      = 1'b1;
        ctrl.instrDone = memReady;
      end
      ST_R_EXEC: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluSrcB = SRCB_B;
        ctrl.aluOp   = ALUOP_FUNCT;
      end
      ST_R_WB: begin
        ctrl.regWrite  = 1'b1;
        ctrl.regDst    = 1'b1;
        ctrl.instrDone = 1'b1;
      end
      ST_BRANCH: begin
        ctrl.aluSrcA     = 1'b1;
        ctrl.aluSrcB     = SRCB_B;
        ctrl.aluOp       = ALUOP_SUB;
        ctrl.pcWriteCond = 1'b1;
        ctrl.pcSource    = PCSRC_ALUOUT;
        ctrl.instrDone   = 1'b1;
      end
      ST_JUMP: begin
        ctrl.pcWrite   = 1'b1;
        ctrl.pcSource  = PCSRC_JUMP;
        ctrl.instrDone = 1'b1;
      end
      ST_ADDI_WB: begin
        ctrl.regWrite  = 1'b1;
        ctrl.instrDone = 1'b1;
      end
      ST_TRAP: ctrl.illegal = 1'b1;
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Moore FSM controller for the multicycle MIPS datapath; 3-5 states per instruction plus one
// cycle per memory wait state (mem_ready low stalls FETCH/MEM_RD/MEM_WR with requests held).
module multicycle_control_unit
  import multicycle_control_unit_pkg::*;
#(
  parameter int OPCODE_W      = 6,
  parameter int OP_RTYPE      = DEF_OP_RTYPE,
  parameter int OP_LW         = DEF_OP_LW,
  parameter int OP_SW         = DEF_OP_SW,
  parameter int OP_BEQ        = DEF_OP_BEQ,
  parameter int OP_J          = DEF_OP_J,
  parameter int OP_ADDI       = DEF_OP_ADDI,
  parameter int ENABLE_JUMP   = 1,
  parameter int ENABLE_ADDI   = 1,
  parameter int USE_MEM_READY = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  output logic                PCWrite,
  output logic                PCWriteCond,
  output logic                IorD,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                IRWrite,
  output logic                MemtoReg,
  output logic                RegDst,
  output logic                RegWrite,
  output logic                ALUSrcA,
  output logic [1:0]          ALUSrcB,
  output logic [1:0]          ALUOp,
  output logic [1:0]          PCSource,
  output logic                instr_done,
  output logic                illegal,
  output logic [3:0]          state
);

  localparam logic [OPCODE_W-1:0] OpRtype = OPCODE_W'(OP_RTYPE);
  localparam logic [OPCODE_W-1:0] OpLw    = OPCODE_W'(OP_LW);
  localparam logic [OPCODE_W-1:0] OpSw    = OPCODE_W'(OP_SW);
  localparam logic [OPCODE_W-1:0] OpBeq   = OPCODE_W'(OP_BEQ);
  localparam logic [OPCODE_W-1:0] OpJ     = OPCODE_W'(OP_J);
  localparam logic [OPCODE_W-1:0] OpAddi  = OPCODE_W'(OP_ADDI);

  logic [3:0]          stateQ;
  logic [OPCODE_W-1:0] opLatched;
  logic                memReady;
  ctrlT                ctrl;
  ctrlT                ctrlOut;

  assign memReady = (USE_MEM_READY != 0) ? mem_ready : 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ    <= ST_FETCH;
      opLatched <= '0;
    end else begin
      case (stateQ)
        ST_FETCH:  if (memReady) stateQ <= ST_DECODE;
        ST_DECODE: begin
          opLatched <= opcode;
          if (opcode == OpRtype)                        stateQ <= ST_R_EXEC;
          else if (opcode == OpLw || opcode == OpSw)    stateQ <= ST_MEM_ADDR;
          else if (opcode == OpBeq)                     stateQ <= ST_BRANCH;
          else if (ENABLE_JUMP != 0 && opcode == OpJ)   stateQ <= ST_JUMP;
          else if (ENABLE_ADDI != 0 && opcode == OpAddi) stateQ <= ST_ADDI_EXEC;
          else                                          stateQ <= ST_TRAP;
        end
        // Steered by the opcode captured in DECODE; the IR input may have moved on
        ST_MEM_ADDR: begin
          if (opLatched == OpLw)      stateQ <= ST_MEM_RD;
          else if (opLatched == OpSw) stateQ <= ST_MEM_WR;
          else                        stateQ <= ST_TRAP;
        end
        ST_MEM_RD:    if (memReady) stateQ <= ST_MEM_WB;
        ST_MEM_WB:    stateQ <= ST_FETCH;
        ST_MEM_WR:    if (memReady) stateQ <= ST_FETCH;
        ST_R_EXEC:    stateQ <= ST_R_WB;
        ST_R_WB:      stateQ <= ST_FETCH;
        ST_BRANCH:    stateQ <= ST_FETCH;
        ST_JUMP:      stateQ <= ST_FETCH;
        ST_ADDI_EXEC: stateQ <= ST_ADDI_WB;
        ST_ADDI_WB:   stateQ <= ST_FETCH;
        ST_TRAP:      stateQ <= ST_TRAP;
        default:      stateQ <= ST_TRAP;
      endcase
    end
  end

  multicycle_ctrl_decode uDecode (
    .state    (stateQ),
    .memReady (memReady),
    .ctrl     (ctrl)
  );

  // Reset kills every request in the same cycle, even mid-access
  assign ctrlOut = rst ? '0 : ctrl;
  assign state   = rst ? 4'd0 : stateQ;

  assign PCWrite     = ctrlOut.pcWrite;
  assign PCWriteCond = ctrlOut.pcWriteCond;
  assign IorD        = ctrlOut.iorD;
  assign MemRead     = ctrlOut.memRead;
  assign MemWrite    = ctrlOut.memWrite;
  assign IRWrite     = ctrlOut.irWrite;
  assign MemtoReg    = ctrlOut.memtoReg;
  assign RegDst      = ctrlOut.regDst;
  assign RegWrite    = ctrlOut.regWrite;
  assign ALUSrcA     = ctrlOut.aluSrcA;
  assign ALUSrcB     = ctrlOut.aluSrcB;
  assign ALUOp       = ctrlOut.aluOp;
  assign PCSource    = ctrlOut.pcSource;
  assign instr_done  = ctrlOut.instrDone;
  assign illegal     = ctrlOut.illegal;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: walks each instruction class state by state and
// compares state plus the full control word against hand-written vectors.
module tb_multicycle_control_unit;

  logic       clk;
  logic       rst;
  logic [5:0] opcode;
  logic       memReady;

  logic       pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite;
  logic       memtoReg, regDst, regWrite, aluSrcA, instrDone, illegal;
  logic [1:0] aluSrcB, aluOp, pcSource;
  logic [3:0] state;

  logic       nPcWrite, nPcWriteCond, nIorD, nMemRead, nMemWrite, nIrWrite;
  logic       nMemtoReg, nRegDst, nRegWrite, nAluSrcA, nInstrDone, nIllegal;
  logic [1:0] nAluSrcB, nAluOp, nPcSource;
  logic [3:0] nState;

  int checks   = 0;
  int failures = 0;

  // Control word order: PCWrite PCWriteCond IorD MemRead MemWrite IRWrite MemtoReg RegDst
  // RegWrite ALUSrcA ALUSrcB[1:0] ALUOp[1:0] PCSource[1:0] instr_done illegal
  logic [17:0] ctlVec, ctlVecNoJ;
  assign ctlVec = {pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite, memtoReg, regDst,
                   regWrite, aluSrcA, aluSrcB, aluOp, pcSource, instrDone, illegal};
  assign ctlVecNoJ = {nPcWrite, nPcWriteCond, nIorD, nMemRead, nMemWrite, nIrWrite, nMemtoReg,
                      nRegDst, nRegWrite, nAluSrcA, nAluSrcB, nAluOp, nPcSource, nInstrDone,
                      nIllegal};

  localparam logic [17:0] C_ZERO       = 18'b0_0_0_0_0_0_0_0_0_0_00_00_00_0_0;
  localparam logic [17:0] C_FETCH_RDY  = 18'b1_0_0_1_0_1_0_0_0_0_01_00_00_0_0;
  localparam logic [17:0] C_FETCH_WAIT = 18'b0_0_0_1_0_0_0_0_0_0_01_00_00_0_0;
  localparam logic [17:0] C_DECODE     = 18'b0_0_0_0_0_0_0_0_0_0_11_00_00_0_0;
  localparam logic [17:0] C_MEM_ADDR   = 18'b0_0_0_0_0_0_0_0_0_1_10_00_00_0_0;
  localparam logic [17:0] C_MEM_RD     = 18'b0_0_1_1_0_0_0_0_0_0_00_00_00_0_0;
  localparam logic [17:0] C_MEM_WB     = 18'b0_0_0_0_0_0_1_0_1_0_00_00_00_1_0;
  localparam logic [17:0] C_MEM_WR_W   = 18'b0_0_1_0_1_0_0_0_0_0_00_00_00_0_0;
  localparam logic [17:0] C_MEM_WR_D   = 18'b0_0_1_0_1_0_0_0_0_0_00_00_00_1_0;
  localparam logic [17:0] C_R_EXEC     = 18'b0_0_0_0_0_0_0_0_0_1_00_10_00_0_0;
  localparam logic [17:0] C_R_WB       = 18'b0_0_0_0_0_0_0_1_1_0_00_00_00_1_0;
  localparam logic [17:0] C_BRANCH     = 18'b0_1_0_0_0_0_0_0_0_1_00_01_01_1_0;
  localparam logic [17:0] C_JUMP       = 18'b1_0_0_0_0_0_0_0_0_0_00_00_10_1_0;
  localparam logic [17:0] C_ADDI_EXEC  = 18'b0_0_0_0_0_0_0_0_0_1_10_00_00_0_0;
  localparam logic [17:0] C_ADDI_WB    = 18'b0_0_0_0_0_0_0_0_1_0_00_00_00_1_0;
  localparam logic [17:0] C_TRAP       = 18'b0_0_0_0_0_0_0_0_0_0_00_00_00_0_1;

  multicycle_control_unit dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(memReady),
    .PCWrite(pcWrite), .PCWriteCond(pcWriteCond), .IorD(iorD), .MemRead(memRead),
    .MemWrite(memWrite), .IRWrite(irWrite), .MemtoReg(memtoReg), .RegDst(regDst),
    .RegWrite(regWrite), .ALUSrcA(aluSrcA), .ALUSrcB(aluSrcB), .ALUOp(aluOp),
    .PCSource(pcSource), .instr_done(instrDone), .illegal(illegal), .state(state)
  );

  multicycle_control_unit #(.ENABLE_JUMP(0)) dutNoJump (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(memReady),
    .PCWrite(nPcWrite), .PCWriteCond(nPcWriteCond), .IorD(nIorD), .MemRead(nMemRead),
    .MemWrite(nMemWrite), .IRWrite(nIrWrite), .MemtoReg(nMemtoReg), .RegDst(nRegDst),
    .RegWrite(nRegWrite), .ALUSrcA(nAluSrcA), .ALUSrcB(nAluSrcB), .ALUOp(nAluOp),
    .PCSource(nPcSource), .instr_done(nInstrDone), .illegal(nIllegal), .state(nState)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic expectStep(input string tag, input int st, input logic [17:0] ctl);
    @(negedge clk);
    check({tag, "_state"}, 32'(state), 32'(st));
    check({tag, "_ctl"}, 32'(ctlVec), 32'(ctl));
    advance();
  endtask

  initial begin
    rst      = 1'b1;
    memReady = 1'b1;
    opcode   = 6'd0;

    @(negedge clk);
    check("reset_ctl", 32'(ctlVec), 32'(C_ZERO));
    check("reset_state", 32'(state), 32'd0);
    check("reset_ctl_nojump", 32'(ctlVecNoJ), 32'(C_ZERO));
    advance();
    rst = 1'b0;

    // R-type, no wait states: 0,1,6,7 then back to 0
    opcode = 6'd0;
    expectStep("r_fetch", 0, C_FETCH_RDY);
    expectStep("r_decode", 1, C_DECODE);
    expectStep("r_exec", 6, C_R_EXEC);
    expectStep("r_wb", 7, C_R_WB);

    // LW with two wait cycles; opcode changes after DECODE to prove it was latched
    opcode = 6'd35;
    expectStep("lw_fetch", 0, C_FETCH_RDY);
    expectStep("lw_decode", 1, C_DECODE);
    opcode = 6'd43;
    expectStep("lw_addr", 2, C_MEM_ADDR);
    memReady = 1'b0;
    expectStep("lw_rd_wait0", 3, C_MEM_RD);
    expectStep("lw_rd_wait1", 3, C_MEM_RD);
    memReady = 1'b1;
    expectStep("lw_rd_done", 3, C_MEM_RD);
    expectStep("lw_wb", 4, C_MEM_WB);

    // BEQ with one fetch wait state
    opcode   = 6'd4;
    memReady = 1'b0;
    expectStep("beq_fetch_wait", 0, C_FETCH_WAIT);
    memReady = 1'b1;
    expectStep("beq_fetch", 0, C_FETCH_RDY);
    expectStep("beq_decode", 1, C_DECODE);
    expectStep("beq_branch", 8, C_BRANCH);

    // SW, memory ready immediately
    opcode = 6'd43;
    expectStep("sw_fetch", 0, C_FETCH_RDY);
    expectStep("sw_decode", 1, C_DECODE);
    expectStep("sw_addr", 2, C_MEM_ADDR);
    expectStep("sw_wr", 5, C_MEM_WR_D);

    // ADDI
    opcode = 6'd8;
    expectStep("addi_fetch", 0, C_FETCH_RDY);
    expectStep("addi_decode", 1, C_DECODE);
    expectStep("addi_exec", 10, C_ADDI_EXEC);
    expectStep("addi_wb", 11, C_ADDI_WB);

    // Illegal opcode parks in TRAP until reset
    opcode = 6'd63;
    expectStep("bad_fetch", 0, C_FETCH_RDY);
    expectStep("bad_decode", 1, C_DECODE);
    for (int i = 0; i < 20; i++) expectStep("trap_hold", 12, C_TRAP);
    rst = 1'b1;
    @(negedge clk);
    check("trap_rst_ctl", 32'(ctlVec), 32'(C_ZERO));
    check("trap_rst_state", 32'(state), 32'd0);
    advance();
    rst = 1'b0;

    // SW stalled in MEM_WR, reset drops MemWrite in the same cycle
    opcode = 6'd43;
    expectStep("swr_fetch", 0, C_FETCH_RDY);
    expectStep("swr_decode", 1, C_DECODE);
    expectStep("swr_addr", 2, C_MEM_ADDR);
    memReady = 1'b0;
    expectStep("swr_wr_wait", 5, C_MEM_WR_W);
    rst = 1'b1;
    @(negedge clk);
    check("swr_rst_memwrite", 32'(memWrite), 32'd0);
    check("swr_rst_ctl", 32'(ctlVec), 32'(C_ZERO));
    advance();
    rst      = 1'b0;
    memReady = 1'b1;

    // Jump: decoded by the default build, illegal in the ENABLE_JUMP=0 build
    opcode = 6'd2;
    expectStep("j_fetch", 0, C_FETCH_RDY);
    expectStep("j_decode", 1, C_DECODE);
    @(negedge clk);
    check("j_state", 32'(state), 32'd9);
    check("j_ctl", 32'(ctlVec), 32'(C_JUMP));
    check("nojump_state", 32'(nState), 32'd12);
    check("nojump_illegal", 32'(nIllegal), 32'd1);
    check("nojump_ctl", 32'(ctlVecNoJ), 32'(C_TRAP));
    advance();
    expectStep("j_return", 0, C_FETCH_RDY);
    @(negedge clk);
    check("nojump_sticky", 32'(nState), 32'd12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
Moore-FSM controller for the multicycle MIPS datapath. It supersedes the single-cycle opcode decoder. Instructions execute over 3-5 states, and memory wait-states are handled through a mem_ready handshake. Opcode values are parametrised, jump and addi support can be enabled per build, and an illegal or disabled opcode parks the unit in a sticky TRAP state.

Parameters:
OPCODE_W, 6, opcode field width
OP_RTYPE, 0, R-type opcode
OP_LW, 35, load-word opcode
OP_SW, 43, store-word opcode
OP_BEQ, 4, branch-equal opcode
OP_J, 2, jump opcode
OP_ADDI, 8, add-immediate opcode
ENABLE_JUMP, 1, 1 = decode OP_J; 0 = OP_J is illegal
ENABLE_ADDI, 1, 1 = decode OP_ADDI; 0 = OP_ADDI is illegal
USE_MEM_READY, 1, 1 = honour mem_ready; 0 = treat memory as single-cycle (mem_ready ignored, taken as 1)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
opcode  in  OPCODE_W  IR[31:26]; sampled only in DECODE
mem_ready  in  1  memory has completed the current access this cycle
PCWrite  out  1  unconditional PC load
PCWriteCond  out  1  PC load qualified by ALU zero (the datapath performs the AND)
IorD  out  1  memory address select: 0 = PC, 1 = ALUOut
MemRead  out  1  memory read request
MemWrite  out  1  memory write request
IRWrite  out  1  instruction register load
MemtoReg  out  1  register write-data select: 1 = MDR
RegDst  out  1  destination select: 1 = rd, 0 = rt
RegWrite  out  1  register file write
ALUSrcA  out  1  0 = PC, 1 = A
ALUSrcB  out  2  00 = B, 01 = 4, 10 = sign-extended imm, 11 = shifted imm
ALUOp  out  2  00 = add, 01 = sub, 10 = funct field
PCSource  out  2  00 = ALU, 01 = ALUOut, 10 = jump target
instr_done  out  1  one-cycle pulse in the final state of each instruction
illegal  out  1  sticky; high while in TRAP
state  out  4  current state, for debug

Behaviour:
- Outputs are decoded combinationally from the registered state. Any output not listed for a state is 0.
- While rst=1, all outputs are forced to 0. At the clock edge with rst=1, state <= FETCH. Reset applied in any state, including mid-MEM_WR, drops requests in that same cycle.
- FETCH(0): MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00. IRWrite and PCWrite are asserted only when mem_ready=1, which also moves the FSM to DECODE. Otherwise the FSM holds in FETCH with MemRead still high.
- DECODE(1): ALUSrcA=0, ALUSrcB=11, ALUOp=00. Next state by opcode:
  - R-type -> R_EXEC
  - LW or SW -> MEM_ADDR
  - BEQ -> BRANCH
  - J -> JUMP, if ENABLE_JUMP
  - ADDI -> ADDI_EXEC, if ENABLE_ADDI
  - anything else -> TRAP
- MEM_ADDR(2): ALUSrcA=1, ALUSrcB=10, ALUOp=00. Goes to MEM_RD for LW, MEM_WR for SW. The opcode is latched in DECODE; the live input is not re-sampled.
- MEM_RD(3): MemRead=1, IorD=1. Holds until mem_ready, then goes to MEM_WB.
- MEM_WB(4): RegWrite=1, MemtoReg=1, RegDst=0, instr_done=1. Then FETCH.
- MEM_WR(5): MemWrite=1, IorD=1. MemWrite stays high throughout the wait. On mem_ready: instr_done=1, then FETCH.
- R_EXEC(6): ALUSrcA=1, ALUSrcB=00, ALUOp=10. Then R_WB.
- R_WB(7): RegWrite=1, RegDst=1, MemtoReg=0, instr_done=1. Then FETCH.
- BRANCH(8): ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, instr_done=1. Then FETCH.
- JUMP(9): PCWrite=1, PCSource=10, instr_done=1. Then FETCH.
- ADDI_EXEC(10): ALUSrcA=1, ALUSrcB=10, ALUOp=00. Then ADDI_WB.
- ADDI_WB(11): RegWrite=1, RegDst=0, MemtoReg=0, instr_done=1. Then FETCH.
- TRAP(12): illegal=1, all write/request outputs 0. Only rst exits.
- Unused encodings 13-15 go to TRAP on the next edge.
- Latency with zero wait-states, counted in cycles from FETCH entry to the next FETCH:
  - R-type 4
  - LW 5
  - SW 4
  - BEQ 3
  - J 3
  - ADDI 4
- Each cycle with mem_ready=0 in FETCH, MEM_RD or MEM_WR adds 1 to the count.

Decomposition:
- Shared package: state encodings (FETCH..TRAP), ALUOp codes (ADD/SUB/FUNCT), ALUSrcB and PCSource codes, default opcode constants.
- One natural sub-module: multicycle_ctrl_decode, a purely combinational state -> control-output decoder. The top level holds the state register, the latched opcode, and the next-state logic.

Test Plan:
1. R-type (opcode 0), mem_ready=1 -> states 0,1,6,7,0. RegWrite=1 and RegDst=1 only in state 7. instr_done pulses once. 4 cycles total.
2. LW (opcode 35), mem_ready low for 2 cycles in MEM_RD -> states 0,1,2,3,3,3,4,0. MemRead=1 and IorD=1 through all MEM_RD cycles. 7 cycles total.
3. BEQ (opcode 4) -> in state 8: PCWriteCond=1, PCSource=01, ALUOp=01, PCWrite=0. Back to FETCH after 3 cycles.
4. Opcode 63 -> TRAP after DECODE; illegal=1; no Mem/Reg/PC writes for 20 cycles. rst returns state to 0 with illegal=0.
5. SW with mem_ready=0, rst asserted in the second MEM_WR cycle -> MemWrite=0 in that same cycle; state=FETCH after the edge.
6. ENABLE_JUMP=0 with opcode 2 -> TRAP. With ENABLE_JUMP=1 -> states 0,1,9,0 and PCSource=10 in state 9.
